pfram_arbiter: RTL

Single-clock arbiter sharing port 1 of the 1024×16 playfield RAM among three requesters: video fetch, CPU bus and a hardware screen-fill engine. Priority is fixed: video > CPU > fill. The block sits between the CPU bus decode and the playfield RAM, and registers every RAM control line. Reads are 16-bit; writes carry upper/lower byte strobes.

---
 rtl/pfram_arbiter_if.sv | 54 +++++
 rtl/pfram_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pfram_arbiter_if.sv
// Request, response and RAM-port signals of the playfield port-1 arbiter.
// The arbiter takes the slave side; the requesters and RAM take the master side.
interface pfram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_a;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_do;

    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_uds;
    logic              cpu_lds;
    logic [ADDR_W-1:0] cpu_a;
    logic [DATA_W-1:0] cpu_di;
    logic [DATA_W-1:0] cpu_do;
    logic              cpu_ack;

    logic              fill_start;
    logic [DATA_W-1:0] fill_val;
    logic              fill_busy;
    logic              fill_done;

    logic [ADDR_W-1:0] p1_a;
    logic [DATA_W-1:0] p1_di;
    logic              p1_r;
    logic              p1_uw;
    logic              p1_lw;
    logic [DATA_W-1:0] p1_do;

    modport slave (
        input  vid_req, vid_a,
        input  cpu_req, cpu_we, cpu_uds, cpu_lds, cpu_a, cpu_di,
        input  fill_start, fill_val,
        input  p1_do,
        output vid_valid, vid_do,
        output cpu_do, cpu_ack,
        output fill_busy, fill_done,
        output p1_a, p1_di, p1_r, p1_uw, p1_lw
    );

    modport master (
        output vid_req, vid_a,
        output cpu_req, cpu_we, cpu_uds, cpu_lds, cpu_a, cpu_di,
        output fill_start, fill_val,
        output p1_do,
        input  vid_valid, vid_do,
        input  cpu_do, cpu_ack,
        input  fill_busy, fill_done,
        input  p1_a, p1_di, p1_r, p1_uw, p1_lw
    );
endinterface

// File: rtl/pfram_arbiter.sv
// Playfield RAM port-1 arbiter: video > CPU > fill, one registered slot per edge.
// Video reads stream every cycle; the CPU runs a req/ack FSM; fill sweeps the RAM.
module pfram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    pfram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        C_IDLE,
        C_RD,
        C_ACK
    } cpu_state_t;

    cpu_state_t state;
    cpu_state_t state_next;

    logic              vid_gnt;
    logic              cpu_gnt;
    logic              fill_gnt;

    logic [ADDR_W-1:0] p1_a;
    logic [DATA_W-1:0] p1_di;
    logic              p1_r;
    logic              p1_uw;
    logic              p1_lw;

    logic              vid_pend;
    logic              vid_valid;

    logic [DATA_W-1:0] cpu_do;
    logic              cpu_ack;
    logic              cpu_rd;

    logic              fill_busy;
    logic              fill_last;
    logic              fill_done;
    logic [ADDR_W-1:0] fill_cnt;
    logic [DATA_W-1:0] fill_data;

    // Slot grant: video always, else a fresh CPU issue, else the fill engine.
    always_comb begin
        vid_gnt  = bus.vid_req;
        cpu_gnt  = !bus.vid_req && (state == C_IDLE) && bus.cpu_req;
        fill_gnt = !bus.vid_req && !cpu_gnt && fill_busy && !fill_last;
    end

    // CPU next state; a write skips C_RD, a video collision keeps us in C_IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            C_IDLE: if (cpu_gnt) state_next = bus.cpu_we ? C_ACK : C_RD;
            C_RD:   state_next = C_ACK;
            C_ACK:  if (!bus.cpu_req) state_next = C_IDLE;
            default: state_next = C_IDLE;
        endcase
    end

    // RAM port register: winner's controls for one cycle, enables cleared otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_a  <= '0;
            p1_di <= '0;
            p1_r  <= 1'b0;
            p1_uw <= 1'b0;
            p1_lw <= 1'b0;
        end else begin
            p1_r  <= 1'b0;
            p1_uw <= 1'b0;
            p1_lw <= 1'b0;
            if (vid_gnt) begin
                p1_a <= bus.vid_a;
                p1_r <= 1'b1;
            end else if (cpu_gnt) begin
                p1_a <= bus.cpu_a;
                if (bus.cpu_we) begin
                    p1_di <= bus.cpu_di;
                    p1_uw <= bus.cpu_uds;
                    p1_lw <= bus.cpu_lds;
                end else begin
                    p1_r <= 1'b1;
                end
            end else if (fill_gnt) begin
                p1_a  <= fill_cnt;
                p1_di <= fill_data;
                p1_uw <= 1'b1;
                p1_lw <= 1'b1;
            end
        end
    end

    // Video strobe trails the grant by two edges, matching RAM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_pend  <= 1'b0;
            vid_valid <= 1'b0;
        end else begin
            vid_pend  <= vid_gnt;
            vid_valid <= vid_pend;
        end
    end

    // CPU state, ack level and read capture on the first ack edge only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= C_IDLE;
            cpu_ack <= 1'b0;
            cpu_do  <= '0;
            cpu_rd  <= 1'b0;
        end else begin
            state <= state_next;
            if (cpu_gnt) cpu_rd <= !bus.cpu_we;
            if (state == C_ACK && bus.cpu_req) begin
                cpu_ack <= 1'b1;
                if (!cpu_ack && cpu_rd) cpu_do <= bus.p1_do;
            end else begin
                cpu_ack <= 1'b0;
            end
        end
    end

    // Fill engine: latch on start when idle, step per granted slot, finish after top word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_busy <= 1'b0;
            fill_last <= 1'b0;
            fill_done <= 1'b0;
            fill_cnt  <= '0;
            fill_data <= '0;
        end else begin
            fill_done <= 1'b0;
            if (fill_last) begin
                fill_busy <= 1'b0;
                fill_last <= 1'b0;
                fill_done <= 1'b1;
            end else if (fill_gnt) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (&fill_cnt) fill_last <= 1'b1;
            end else if (bus.fill_start && !fill_busy) begin
                fill_busy <= 1'b1;
                fill_cnt  <= '0;
                fill_data <= bus.fill_val;
            end
        end
    end

    assign bus.p1_a      = p1_a;
    assign bus.p1_di     = p1_di;
    assign bus.p1_r      = p1_r;
    assign bus.p1_uw     = p1_uw;
    assign bus.p1_lw     = p1_lw;
    assign bus.vid_valid = vid_valid;
    // Gated so the data bus reads zero whenever no video word is presented.
    assign bus.vid_do    = vid_valid ? bus.p1_do : '0;
    assign bus.cpu_do    = cpu_do;
    assign bus.cpu_ack   = cpu_ack;
    assign bus.fill_busy = fill_busy;
    assign bus.fill_done = fill_done;
endmodule
